// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One operand bit is consumed per clock; ready/valid handshakes on both sides.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    // True when DIGITS decimal digits can represent 2^WIDTH - 1.
    function automatic bit digits_fit(input int unsigned w, input int unsigned d);
        longint unsigned max_val;
        longint unsigned pow10;
        max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        pow10   = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 64'd10;
            end
        end
        return pow10 > max_val;
    endfunction

    if (WIDTH < 1) begin : g_bad_width
        $error("bin_to_bcd_seq: WIDTH must be at least 1");
    end
    if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    bin_reg;
    logic [4*DIGITS-1:0] dig_reg;
    logic [4*DIGITS-1:0] dig_adj;
    logic [CW-1:0]       cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; SHIFT ends on the step that takes the counter to zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        dig_adj = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (dig_reg[4*k +: 4] >= 4'd5) begin
                dig_adj[4*k +: 4] = dig_reg[4*k +: 4] + 4'd3;
            end else begin
                dig_adj[4*k +: 4] = dig_reg[4*k +: 4];
            end
        end
    end

    // Datapath: load on accept, shift {digits, binary} left once per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg <= '0;
            dig_reg <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_reg <= in_bin;
                        dig_reg <= '0;
                        cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    dig_reg <= {dig_adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};
                    bin_reg <= bin_reg << 1;
                    cnt     <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_bcd = dig_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: driver pushes decimal reference results
// on accept, a negedge monitor pops and compares on each output handshake.
module tb_bin_to_bcd_seq;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_bin;
    logic           out_valid;
    logic           out_ready;
    logic [4*D-1:0] out_bcd;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned    n_cmp = 0;
    int unsigned    n_bad = 0;
    int unsigned    cyc   = 0;
    logic [4*D-1:0] exp_q[$];
    bit             chk_spacing = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: peel off base-10 digits arithmetically.
    function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned    x;
        r = '0;
        x = v;
        for (int k = 0; k < int'(D); k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Offer v until accepted; push the expected result on the accepting edge.
    task automatic send(input int unsigned v, input bit drop);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bin   = W'(v);
        for (int g = 0; g < 60; g++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(to_bcd(v));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", {63'd0, in_ready}, 64'd1);
        if (drop) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor state
    int unsigned    acc_e;
    int unsigned    prev_acc;
    bit             have_acc;
    bit             have_prev_acc;
    bit             prev_ov;
    bit             prev_stall;
    logic [4*D-1:0] prev_bcd;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_acc      = 1'b0;
            have_prev_acc = 1'b0;
            prev_ov       = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            if (!chk_spacing) have_prev_acc = 1'b0;
            check("ready_valid_excl", {63'd0, in_ready & out_valid}, 64'd0);
            if (in_valid && in_ready) begin
                if (have_prev_acc) check("accept_spacing", 64'(cyc + 1 - prev_acc), 64'(W + 2));
                prev_acc      = cyc + 1;
                have_prev_acc = 1'b1;
                acc_e         = cyc + 1;
                have_acc      = 1'b1;
            end
            if (out_valid && !prev_ov && have_acc) check("latency", 64'(cyc - acc_e), 64'(W));
            if (prev_stall) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold", 64'(out_bcd), 64'(prev_bcd));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", {63'd0, out_valid}, 64'd0);
                else check("result", 64'(out_bcd), 64'(exp_q.pop_front()));
            end
            prev_ov    = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_bcd   = out_bcd;
        end
    end

    bit bp_done;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_bcd", 64'(out_bcd), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Directed corner values
        out_ready = 1'b1;
        send(0, 1'b1);
        send(255, 1'b1);
        send(99, 1'b1);
        send(100, 1'b1);

        // Exhaustive sweep with in_valid held high and no backpressure
        repeat (12) @(posedge clk);
        chk_spacing = 1'b1;
        for (int v = 0; v < 256; v++) send(v, v == 255);
        repeat (12) @(posedge clk);
        chk_spacing = 1'b0;

        // Output stall with a competing operand offered
        #1;
        out_ready = 1'b0;
        send(37, 1'b1);
        for (int g = 0; g < 30; g++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bin   = W'(200);
        repeat (6) begin
            @(negedge clk);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_bcd_037", 64'(out_bcd), 64'h037);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(200, 1'b1);

        // Random operands with random gaps and random backpressure
        bp_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send($urandom_range(0, 255), 1'b1);
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

        // Let the pipeline drain before the reset abort
        for (int g = 0; g < 40 && exp_q.size() > 0; g++) @(negedge clk);

        // Reset during SHIFT aborts the conversion
        send($urandom_range(1, 255), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_out_bcd", 64'(out_bcd), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("abort_no_result", {63'd0, out_valid}, 64'd0);
        end
        send(42, 1'b1);

        for (int g = 0; g < 60 && exp_q.size() > 0; g++) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
